// File: rtl/host_pio_gen_if.sv
// AXI-Stream style PCIe RX request channel carrying generated PIO TLPs.
// master drives the beats, slave supplies tready.
interface host_pio_gen_if;
  logic        tvalid;
  logic        tready;
  logic        tlast;
  logic [7:0]  tkeep;
  logic [63:0] tdata;
  logic [21:0] tuser;

  modport master (
    output tvalid,
    output tlast,
    output tkeep,
    output tdata,
    output tuser,
    input  tready
  );

  modport slave (
    input  tvalid,
    input  tlast,
    input  tkeep,
    input  tdata,
    input  tuser,
    output tready
  );
endinterface

// File: rtl/host_pio_gen.sv
// Host PIO request generator: emits a run of 3DW, length-1 MWr/MRd TLPs as
// two 64-bit beats each, with optional idle gaps between TLPs.
module host_pio_gen #(
  parameter int unsigned NUM_REQ     = 16,
  parameter int unsigned MODE        = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned ADDR_STRIDE = 4,
  parameter int unsigned GAP_CYCLES  = 0,
  parameter logic [15:0] REQ_ID      = 16'h0100,
  parameter logic [31:0] DATA_SEED   = 32'hA5A5_0000,
  parameter logic [7:0]  BAR_HIT     = 8'h01
) (
  input  logic                  pcie_clk,
  input  logic                  sys_rst_n,
  input  logic                  start,
  host_pio_gen_if.master        pcie_rx,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           sent_cnt
);

  localparam logic [15:0] NumReq    = 16'(NUM_REQ);
  localparam logic [31:0] Stride    = 32'(ADDR_STRIDE);
  localparam logic [7:0]  GapLast   = 8'(GAP_CYCLES - 1);
  localparam logic [21:0] UserValid = {12'h000, BAR_HIT, 2'b00};

  typedef enum logic [1:0] {StIdle, StGap, StBeat0, StBeat1} state_e;

  state_e      state_q;
  logic [15:0] sent_cnt_q;
  logic [31:0] addr_q;
  logic [7:0]  gap_q;
  logic        busy_q;
  logic        done_q;
  logic        tvalid_q;
  logic        tlast_q;
  logic [7:0]  tkeep_q;
  logic [63:0] tdata_q;
  logic [21:0] tuser_q;

  logic [15:0] nxt_cnt;
  logic [31:0] nxt_addr;
  logic        last_tlp;

  // TLP n is a write when MODE says so; MODE 2 writes on even n.
  function automatic logic is_wr(input logic n0);
    return (MODE == 1) || ((MODE == 2) && !n0);
  endfunction

  function automatic logic [63:0] beat0(input logic [7:0] tag);
    logic [31:0] dw0;
    dw0 = is_wr(tag[0]) ? 32'h4000_0001 : 32'h0000_0001;
    return {REQ_ID, tag, 4'h0, 4'hF, dw0};
  endfunction

  function automatic logic [63:0] beat1(input logic [15:0] n, input logic [29:0] addr_dw);
    logic [31:0] payload;
    payload = is_wr(n[0]) ? (DATA_SEED + {16'h0000, n}) : 32'h0000_0000;
    return {payload, addr_dw, 2'b00};
  endfunction

  always_comb begin
    nxt_cnt  = sent_cnt_q + 16'd1;
    nxt_addr = addr_q + Stride;
    last_tlp = (nxt_cnt == NumReq);
  end

  always_ff @(posedge pcie_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= StIdle;
      sent_cnt_q <= 16'h0000;
      addr_q     <= 32'h0000_0000;
      gap_q      <= 8'h00;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      tvalid_q   <= 1'b0;
      tlast_q    <= 1'b0;
      tkeep_q    <= 8'h00;
      tdata_q    <= 64'h0;
      tuser_q    <= 22'h0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            sent_cnt_q <= 16'h0000;
            addr_q     <= BASE_ADDR;
            gap_q      <= 8'h00;
            if (NumReq != 16'h0000) begin
              state_q  <= StBeat0;
              busy_q   <= 1'b1;
              tvalid_q <= 1'b1;
              tlast_q  <= 1'b0;
              tkeep_q  <= 8'hFF;
              tdata_q  <= beat0(8'h00);
              tuser_q  <= UserValid;
            end else begin
              // Empty run: completes immediately without ever going busy.
              done_q <= 1'b1;
            end
          end
        end
        StBeat0: begin
          if (pcie_rx.tready) begin
            state_q <= StBeat1;
            tlast_q <= 1'b1;
            tkeep_q <= is_wr(sent_cnt_q[0]) ? 8'hFF : 8'h0F;
            tdata_q <= beat1(sent_cnt_q, addr_q[31:2]);
          end
        end
        StBeat1: begin
          if (pcie_rx.tready) begin
            sent_cnt_q <= nxt_cnt;
            addr_q     <= nxt_addr;
            tlast_q    <= 1'b0;
            if (last_tlp || (GAP_CYCLES != 0)) begin
              state_q  <= last_tlp ? StIdle : StGap;
              gap_q    <= 8'h00;
              tvalid_q <= 1'b0;
              tkeep_q  <= 8'h00;
              tdata_q  <= 64'h0;
              tuser_q  <= 22'h0;
              busy_q   <= !last_tlp;
              done_q   <= last_tlp;
            end else begin
              state_q <= StBeat0;
              tkeep_q <= 8'hFF;
              tdata_q <= beat0(nxt_cnt[7:0]);
            end
          end
        end
        StGap: begin
          if (gap_q == GapLast) begin
            state_q  <= StBeat0;
            tvalid_q <= 1'b1;
            tlast_q  <= 1'b0;
            tkeep_q  <= 8'hFF;
            tdata_q  <= beat0(sent_cnt_q[7:0]);
            tuser_q  <= UserValid;
          end else begin
            gap_q <= gap_q + 8'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign pcie_rx.tvalid = tvalid_q;
  assign pcie_rx.tlast  = tlast_q;
  assign pcie_rx.tkeep  = tkeep_q;
  assign pcie_rx.tdata  = tdata_q;
  assign pcie_rx.tuser  = tuser_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign sent_cnt       = sent_cnt_q;

endmodule

// File: doc/host_pio_gen.md
HOST_PIO_GEN -- requirements
Module: host_pio_gen

Interface
REQ-001 SHALL have parameter NUM_REQ, default 16: TLPs per run, 0..65535.
REQ-002 SHALL have parameter MODE, default 2: 0 = MRd only, 1 = MWr only, 2 = alternate MWr/MRd starting with MWr.
REQ-003 SHALL have parameter BASE_ADDR, default 32'h0000_0000: DW-aligned address of the first TLP.
REQ-004 SHALL have parameter ADDR_STRIDE, default 4: byte increment per TLP, taken modulo 2^32.
REQ-005 SHALL have parameter GAP_CYCLES, default 0: idle cycles between TLPs, 0..255.
REQ-006 SHALL have parameter REQ_ID, default 16'h0100: requester ID.
REQ-007 SHALL have parameter DATA_SEED, default 32'hA5A5_0000: payload of TLP n is DATA_SEED + n.
REQ-008 SHALL have parameter BAR_HIT, default 8'h01: value driven on tuser[9:2] during valid beats.
REQ-009 pcie_clk  in  1  sole clock; all logic on the rising edge.
REQ-010 sys_rst_n  in  1  asynchronous, active-low reset.
REQ-011 start  in  1  single-cycle pulse that begins a run.
REQ-012 pcie_rx_tready  in  1  sink ready.
REQ-013 pcie_rx_tvalid  out  1  beat valid.
REQ-014 pcie_rx_tlast  out  1  last beat of a TLP.
REQ-015 pcie_rx_tkeep  out  8  byte enables.
REQ-016 pcie_rx_tdata  out  64  beat data.
REQ-017 pcie_rx_tuser  out  22  sideband.
REQ-018 busy  out  1  run in progress.
REQ-019 done  out  1  one-cycle pulse when a run completes.
REQ-020 sent_cnt  out  16  TLPs accepted in the current or last run.

Function
REQ-021 Each TLP SHALL be 3DW with length 1 and two beats.
- Beat 0: tdata[31:0] = DW0, tdata[63:32] = DW1, tkeep = 8'hFF, tlast = 0.
- Beat 1: tdata[31:0] = DW2, tlast = 1.
REQ-022 DW0 SHALL be 32'h4000_0001 for MWr and 32'h0000_0001 for MRd.
- DW1 = {REQ_ID, tag[7:0], 4'h0, 4'hF}.
- DW2 = {addr[31:2], 2'b00}.
REQ-023 On beat 1, MWr SHALL drive tdata[63:32] = payload with tkeep = 8'hFF; MRd SHALL drive tdata[63:32] = 0 with tkeep = 8'h0F.
REQ-024 FSM states SHALL be IDLE, GAP, BEAT0, BEAT1.
- IDLE -> BEAT0 on start when NUM_REQ != 0.
- BEAT0 -> BEAT1 on tvalid && tready.
- BEAT1 -> GAP on acceptance when GAP_CYCLES != 0 and TLPs remain; -> BEAT0 when GAP_CYCLES == 0 and TLPs remain; -> IDLE after the last TLP.
- GAP -> BEAT0 after exactly GAP_CYCLES cycles.
REQ-025 tvalid SHALL be high exactly in BEAT0/BEAT1. Once asserted, tvalid, tdata, tkeep, tlast and tuser SHALL hold stable until tready is sampled high.
REQ-026 The first beat SHALL appear the cycle after start is sampled; with GAP_CYCLES = 0 and tready held high, TLPs SHALL stream back-to-back (2 cycles per TLP).
REQ-027 tag SHALL start at 0 each run and increment by 1 per accepted TLP, wrapping 255 -> 0; addr SHALL start at BASE_ADDR and wrap modulo 2^32.
REQ-028 tuser SHALL be {12'h0, BAR_HIT, 2'b00} while tvalid is high, else 22'h0.
REQ-029 sent_cnt SHALL clear on accepted start and increment on each accepted beat 1.
REQ-030 busy SHALL be high from the cycle after accepted start until the cycle after the last beat-1 acceptance.
REQ-031 done SHALL pulse for one cycle coincident with busy falling.
REQ-032 start while busy SHALL be ignored.
REQ-033 start with NUM_REQ = 0 SHALL emit no beats, leave busy low, and pulse done the next cycle.
REQ-034 When NUM_REQ = 65535, sent_cnt SHALL reach 65535 without wrap.

Reset
REQ-035 While sys_rst_n is low, all outputs SHALL be 0 (tvalid, tlast, tkeep, tdata, tuser, busy, done, sent_cnt) and the FSM SHALL be in IDLE, asynchronously.
REQ-036 Reset mid-TLP SHALL abort immediately, with no completion of the partial TLP. After release, the block SHALL wait for a new start.

Verification
REQ-037 Defaults with tready = 1, start pulse -> 16 TLPs in 32 consecutive valid cycles.
- First TLP: beat 0 tdata = 64'h0100_000F_4000_0001; beat 1 tdata = 64'hA5A5_0000_0000_0000, tkeep = FF.
- Second TLP is MRd: beat 1 tkeep = 0F, DW2 = 4.
- done pulses once; sent_cnt = 16.
REQ-038 tready toggling pseudo-randomly -> no beat dropped or duplicated, outputs stable while stalled, and the TLP sequence is identical to REQ-037.
REQ-039 GAP_CYCLES = 3, MODE = 0 -> exactly 3 idle cycles between each tlast acceptance and the next tvalid; all TLPs are MRd.
REQ-040 NUM_REQ = 300 -> tag 255 is followed by tag 0; sent_cnt = 300. BASE_ADDR = 32'hFFFF_FFFC -> second addr = 0.
REQ-041 sys_rst_n low during BEAT1 -> all outputs 0 the same cycle.
- After release with no start: tvalid stays 0.
- Next start: tag = 0, addr = BASE_ADDR.
REQ-042 NUM_REQ = 0 start -> no tvalid, done pulses once. A second start while busy during a normal run -> ignored, sent_cnt = NUM_REQ.
